skew_offset_accum: RTL and testbench

Pipelined, parametrised successor to the combinational skewed-offset adder. Each input beat carries one SIZE_CODE-bit count code per input bit position. The block significance-aligns (skews) the codes into a signed weighted sum, with the MSB column carrying negative weight. It accumulates that sum across a multi-beat batch onto a loaded initial value and presents the registered result to the downstream neuron/activation stage through a valid/ready handshake.

---
 rtl/skew_offset_pkg.sv | 24 ++
 rtl/skew_offset_accum_if.sv | 28 ++
 rtl/skew_offset_reduce.sv | 28 ++
 rtl/skew_offset_accum.sv | 140 ++++++++++++++
 tb/tb_skew_offset_accum.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/skew_offset_pkg.sv
// Shared state encoding and width/saturation-bound helpers for the skewed-offset accumulator.
package skew_offset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    function automatic int sum_width(input int size_input, input int size_code);
        return size_input + size_code;
    endfunction

    // Two's-complement clamp bounds for a w-bit signed accumulator (w <= 63).
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/skew_offset_accum_if.sv
// Beat-in / result-out handshake bundle for skew_offset_accum; the block itself binds the slave modport.
interface skew_offset_accum_if #(
    parameter int SIZE_INPUT  = 8,
    parameter int SIZE_CODE   = 5,
    parameter int SIZE_OUTPUT = 16
);
    logic        [SIZE_INPUT*SIZE_CODE-1:0] offset;
    logic signed [SIZE_OUTPUT-1:0]          acc_init;
    logic                                   in_valid;
    logic                                   in_first;
    logic                                   in_last;
    logic                                   in_ready;
    logic signed [SIZE_OUTPUT-1:0]          out;
    logic                                   out_valid;
    logic                                   out_ready;
    logic                                   sat;
    logic                                   err;

    modport master (
        output offset, acc_init, in_valid, in_first, in_last, out_ready,
        input  in_ready, out, out_valid, sat, err
    );

    modport slave (
        input  offset, acc_init, in_valid, in_first, in_last, out_ready,
        output in_ready, out, out_valid, sat, err
    );
endinterface

// File: rtl/skew_offset_reduce.sv
// Combinational skew of one beat's count codes into a signed weighted sum;
// code column i is weighted by 2^i and the top column carries negative weight.
module skew_offset_reduce
    import skew_offset_pkg::*;
#(
    parameter int SIZE_INPUT = 8,
    parameter int SIZE_CODE  = 5,
    parameter int SUM_W      = sum_width(SIZE_INPUT, SIZE_CODE)
) (
    input  logic        [SIZE_INPUT*SIZE_CODE-1:0] offset,
    output logic signed [SUM_W-1:0]                sum
);

    logic signed [SUM_W-1:0] term;

    always_comb begin
        term = '0;
        sum  = '0;
        for (int i = 0; i < SIZE_INPUT; i++) begin
            term = $signed(SUM_W'(offset[i*SIZE_CODE +: SIZE_CODE])) <<< i;
            if (i == SIZE_INPUT - 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
    end

endmodule

// File: rtl/skew_offset_accum.sv
// Skewed-offset batch accumulator: reduce -> stage-1 beat register -> stage-2 accumulator -> held result.
// Defining SKEW_ACC_SAT_EN compiles in clamping accumulation and a sticky per-batch sat flag.
module skew_offset_accum
    import skew_offset_pkg::*;
#(
    parameter int SIZE_INPUT  = 8,
    parameter int SIZE_CODE   = 5,
    parameter int SIZE_OUTPUT = 16
) (
    input logic                clk,
    input logic                rst,
    skew_offset_accum_if.slave bus
);

    localparam int SUM_W = sum_width(SIZE_INPUT, SIZE_CODE);

    state_t                        state, state_nxt;
    logic                          in_ready;
    logic                          accept;
    logic                          err_d, err_q;
    logic signed [SUM_W-1:0]       sum_p0;
    logic signed [SUM_W-1:0]       sum_p1;
    logic signed [SIZE_OUTPUT-1:0] init_p1;
    logic                          first_p1;
    logic                          vld_p1;
    logic signed [SIZE_OUTPUT-1:0] base_p1;
    logic signed [SIZE_OUTPUT-1:0] sum_ext_p1;
    logic signed [SIZE_OUTPUT-1:0] acc_nxt;
    logic signed [SIZE_OUTPUT-1:0] acc_p2;

    skew_offset_reduce #(
        .SIZE_INPUT (SIZE_INPUT),
        .SIZE_CODE  (SIZE_CODE),
        .SUM_W      (SUM_W)
    ) u_reduce (
        .offset (bus.offset),
        .sum    (sum_p0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DRAIN covers the cycle in which stage 2 folds in the last beat.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_first)
                    state_nxt = bus.in_last ? DRAIN : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last)
                    state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A beat arriving in IDLE without in_first is dropped and flagged.
    assign accept = bus.in_valid && in_ready && (state != IDLE || bus.in_first);
    assign err_d  = bus.in_valid && (state == IDLE) && !bus.in_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    // ---- stage 1: registered per-beat sum and batch-start flag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sum_p1   <= sum_p0;
            first_p1 <= bus.in_first;
            if (bus.in_first)
                init_p1 <= bus.acc_init;
        end
    end

    // ---- stage 2: accumulate onto acc_init (batch start) or the running total ----
    assign base_p1    = first_p1 ? init_p1 : acc_p2;
    assign sum_ext_p1 = SIZE_OUTPUT'(sum_p1);

`ifdef SKEW_ACC_SAT_EN
    localparam logic signed [SIZE_OUTPUT-1:0] ACC_MAX = SIZE_OUTPUT'(sat_max(SIZE_OUTPUT));
    localparam logic signed [SIZE_OUTPUT-1:0] ACC_MIN = SIZE_OUTPUT'(sat_min(SIZE_OUTPUT));

    logic clip_p1;
    logic sat_p2;

    // Returns {clipped, value}; overflow shows as disagreement of the two top bits of the widened sum.
    function automatic logic [SIZE_OUTPUT:0] sat_add(input logic signed [SIZE_OUTPUT-1:0] a,
                                                     input logic signed [SIZE_OUTPUT-1:0] b);
        logic signed [SIZE_OUTPUT:0] wide;
        wide = (SIZE_OUTPUT+1)'(a) + (SIZE_OUTPUT+1)'(b);
        if (wide[SIZE_OUTPUT] != wide[SIZE_OUTPUT-1])
            return {1'b1, (wide[SIZE_OUTPUT] ? ACC_MIN : ACC_MAX)};
        return {1'b0, wide[SIZE_OUTPUT-1:0]};
    endfunction

    assign {clip_p1, acc_nxt} = sat_add(base_p1, sum_ext_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sat_p2 <= 1'b0;
        else if (vld_p1) sat_p2 <= clip_p1 | (sat_p2 & ~first_p1);
    end

    assign bus.sat = sat_p2;
`else
    function automatic logic signed [SIZE_OUTPUT-1:0] wrap_add(input logic signed [SIZE_OUTPUT-1:0] a,
                                                               input logic signed [SIZE_OUTPUT-1:0] b);
        return a + b;
    endfunction

    assign acc_nxt = wrap_add(base_p1, sum_ext_p1);
    assign bus.sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc_p2 <= '0;
        else if (vld_p1) acc_p2 <= acc_nxt;
    end

    // ---- result: the accumulator is held stable in HOLD since no beats are accepted there ----
    assign bus.in_ready  = in_ready;
    assign bus.out       = acc_p2;
    assign bus.out_valid = (state == HOLD);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_skew_offset_accum.sv
// Directed self-checking bench for skew_offset_accum (8 columns, 5-bit codes, 16-bit result).
module tb_skew_offset_accum;

    localparam int SI = 8;
    localparam int SC = 5;
    localparam int SO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    skew_offset_accum_if #(.SIZE_INPUT(SI), .SIZE_CODE(SC), .SIZE_OUTPUT(SO)) bus ();

    skew_offset_accum #(.SIZE_INPUT(SI), .SIZE_CODE(SC), .SIZE_OUTPUT(SO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.offset   = '0;
        bus.acc_init = '0;
    endtask

    task automatic beat(input int col, input int code, input int init, input logic first, input logic last);
        bus.offset = '0;
        bus.offset[col*SC +: SC] = code[SC-1:0];
        bus.acc_init = init[SO-1:0];
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
    endtask

    // Called in cycle t+1 after the last beat; returns what is presented in cycle t+2, then completes the handshake.
    task automatic collect(output logic vld, output logic [SO-1:0] res, output logic s);
        idle_inputs();
        tick();
        vld = bus.out_valid;
        res = bus.out;
        s   = bus.sat;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        idle_inputs();
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", bus.out); end
        checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", bus.sat); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_one_beat();
        beat(0, 3, 10, 1'b1, 1'b1);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL one_beat_ready_t1 got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL one_beat_valid_t1 got %b want 0", bus.out_valid); end
        idle_inputs();
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL one_beat_valid_t2 got %b want 1", bus.out_valid); end
        checks++; if (bus.out !== 16'd13) begin errors++; $display("FAIL one_beat_out got %h want %h", bus.out, 16'd13); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL one_beat_err got %b want 0", bus.err); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL one_beat_valid_t3 got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL one_beat_ready_t3 got %b want 1", bus.in_ready); end
    endtask

    task automatic test_sign_column();
        logic v, s;
        logic [SO-1:0] r;
        beat(7, 1, 0, 1'b1, 1'b1);
        tick();
        collect(v, r, s);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL sign_valid got %b want 1", v); end
        checks++; if (r !== 16'hFF80) begin errors++; $display("FAIL sign_out got %h want ff80", r); end
    endtask

    task automatic test_back_to_back();
        logic v, s;
        logic [SO-1:0] r;
        for (int i = 0; i < 4; i++) begin
            beat(1, 31, 0, (i == 0), (i == 3));
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_beat%0d got %b want 1", i, bus.in_ready); end
            tick();
        end
        collect(v, r, s);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", v); end
        checks++; if (r !== 16'd248) begin errors++; $display("FAIL b2b_out got %h want %h", r, 16'd248); end
    endtask

    task automatic test_overflow();
        logic v, s;
        logic [SO-1:0] r;
        logic [SO-1:0] exp_r;
        logic exp_s;
`ifdef SKEW_ACC_SAT_EN
        exp_r = 16'h7FFF;
        exp_s = 1'b1;
`else
        exp_r = 16'h87B0;
        exp_s = 1'b0;
`endif
        beat(6, 31, 32'h7FF0, 1'b1, 1'b1);
        tick();
        collect(v, r, s);
        checks++; if (r !== exp_r) begin errors++; $display("FAIL overflow_out got %h want %h", r, exp_r); end
        checks++; if (s !== exp_s) begin errors++; $display("FAIL overflow_sat got %b want %b", s, exp_s); end
    endtask

    task automatic test_sat_clear();
        logic v, s;
        logic [SO-1:0] r;
        beat(0, 1, 0, 1'b1, 1'b1);
        tick();
        collect(v, r, s);
        checks++; if (r !== 16'd1) begin errors++; $display("FAIL sat_clear_out got %h want 0001", r); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL sat_clear_sat got %b want 0", s); end
    endtask

    task automatic test_restart();
        logic v, s;
        logic [SO-1:0] r;
        beat(0, 1, 1000, 1'b1, 1'b0);
        tick();
        beat(0, 2, 50, 1'b1, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b want 1", bus.in_ready); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL restart_err got %b want 0", bus.err); end
        collect(v, r, s);
        checks++; if (r !== 16'd52) begin errors++; $display("FAIL restart_out got %h want %h", r, 16'd52); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(0, 5, 100, 1'b1, 1'b1);
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", bus.out_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.out !== 16'd105) begin errors++; $display("FAIL bp_out_c%0d got %h want %h", i, bus.out, 16'd105); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got %b want 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_batch();
        beat(0, 1, 0, 1'b1, 1'b0);
        tick();
        beat(0, 1, 0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL midrst_out got %h want 0000", bus.out); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", bus.out_valid); end
        checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL midrst_acc got %h want 0000", bus.out); end
    endtask

    task automatic test_protocol_err();
        logic v, s;
        logic [SO-1:0] r;
        beat(0, 7, 0, 1'b0, 1'b1);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL perr_before got %b want 0", bus.err); end
        tick();
        idle_inputs();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL perr_pulse got %b want 1", bus.err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL perr_ready got %b want 1", bus.in_ready); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL perr_clear got %b want 0", bus.err); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL perr_no_result got %b want 0", bus.out_valid); end
        beat(2, 3, -5, 1'b1, 1'b1);
        tick();
        collect(v, r, s);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL perr_next_valid got %b want 1", v); end
        checks++; if (r !== 16'd7) begin errors++; $display("FAIL perr_next_out got %h want 0007", r); end
    endtask

    initial begin
        test_reset();
        test_one_beat();
        test_sign_column();
        test_back_to_back();
        test_overflow();
        test_sat_clear();
        test_restart();
        test_backpressure();
        test_reset_mid_batch();
        test_protocol_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
